// File: rtl/fpga_pkg.sv
// fpga_pkg: shared types for the AXI read arbiter.
// Contents:
//   rd_src_e    read requester id (icache refill, dcache miss, dcache uncached)
//   RD_TAG_W    width of the source tag prepended to ARID/RID
//   RD_TAG_BAD  tag value that maps to no source
//   arb_state_e AR issue FSM states
//   rr_next     round-robin successor over the three sources
package fpga_pkg;
    typedef enum logic [1:0] {
        RD_SRC_ICACHE = 2'd0,
        RD_SRC_DMISS  = 2'd1,
        RD_SRC_DUC    = 2'd2
    } rd_src_e;

    localparam int RD_TAG_W = 2;
    localparam logic [RD_TAG_W-1:0] RD_TAG_BAD = 2'd3;

    typedef enum logic {
        ARB_IDLE,
        ARB_HOLD
    } arb_state_e;

    function automatic logic [1:0] rr_next(input logic [1:0] g);
        return (g == RD_SRC_DUC) ? RD_SRC_ICACHE : g + 2'd1;
    endfunction
endpackage

// File: rtl/axi_rd_arbiter_rr_arb3.sv
// rr_arb3: three-input round-robin arbiter.
// Ports:
//   req_i  requests, one bit per source
//   ptr_i  highest-priority source this round (0..2)
//   gnt_o  one-hot grant, zero when nothing requests
module rr_arb3
    import fpga_pkg::*;
(
    input  logic [2:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [2:0] gnt_o
);
    logic [3:0] req_x;
    logic [1:0] p1, p2, idx;

    // Search order is ptr, ptr+1, ptr+2 (mod 3); req_x pads the unused index 3.
    always_comb begin
        req_x = {1'b0, req_i};
        p1    = rr_next(ptr_i);
        p2    = rr_next(p1);
        idx   = req_x[ptr_i] ? ptr_i : req_x[p1] ? p1 : p2;
        gnt_o = req_x[idx] ? 3'b001 << idx : 3'b000;
    end
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 read channel (AR/R) among three requesters
// (src0 icache refill, src1 dcache miss, src2 dcache uncached).
// AR: round-robin grant, request registered and held until the master accepts it,
//     master ARID = {source tag, source id}. Each source may have MAX_OUT reads in flight.
// R:  combinational routing by RID tag; tag 3 beats are accepted and dropped and set bad_tag_o.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   src_ar_* (valid/ready/addr/len/id) per-source AR request, fields packed 3-wide
//   src_r_valid_o / src_r_ready_i      per-source R handshake
//   src_r_data/id/resp/last_o          shared R payload, RID with tag stripped
//   m_ar_* / m_r_*                     master side AR and R channels, ID width ID_W+2
//   bad_tag_o                          sticky flag: a beat with RID tag 3 arrived
// Optional feature: define AXI_RD_ARB_PERF_EN to add perf_grant_cnt_o (AR handshakes
// per source, 3x32) and perf_stall_cnt_o (cycles AR valid without ready), both wrapping.
module axi_rd_arbiter
    import fpga_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 4,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [2:0]               src_ar_valid_i,
    output logic [2:0]               src_ar_ready_o,
    input  logic [3*ADDR_W-1:0]      src_ar_addr_i,
    input  logic [3*8-1:0]           src_ar_len_i,
    input  logic [3*ID_W-1:0]        src_ar_id_i,
    output logic [2:0]               src_r_valid_o,
    input  logic [2:0]               src_r_ready_i,
    output logic [DATA_W-1:0]        src_r_data_o,
    output logic [ID_W-1:0]          src_r_id_o,
    output logic [1:0]               src_r_resp_o,
    output logic                     src_r_last_o,
    output logic                     m_ar_valid_o,
    input  logic                     m_ar_ready_i,
    output logic [ADDR_W-1:0]        m_ar_addr_o,
    output logic [7:0]               m_ar_len_o,
    output logic [ID_W+RD_TAG_W-1:0] m_ar_id_o,
    input  logic                     m_r_valid_i,
    output logic                     m_r_ready_o,
    input  logic [DATA_W-1:0]        m_r_data_i,
    input  logic [ID_W+RD_TAG_W-1:0] m_r_id_i,
    input  logic [1:0]               m_r_resp_i,
    input  logic                     m_r_last_i,
    output logic                     bad_tag_o
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [3*32-1:0]          perf_grant_cnt_o,
    output logic [31:0]              perf_stall_cnt_o
`endif
);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;
    typedef logic [CNT_W-1:0] cnt_t;

    arb_state_e        state_q, state_d;
    logic [1:0]        ptr_q, ptr_d, tag_q, tag_d, gnt_idx, r_tag;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [ID_W-1:0]   id_q, id_d;
    cnt_t [2:0]        cnt_q, cnt_d;
    logic              bad_tag_q, bad_tag_d;
    logic [2:0]        full, eligible, gnt, inc, dec;
    logic [3:0]        r_ready_x;
    logic              ar_hs, r_last_hs;

    always_comb begin
        for (int s = 0; s < 3; s++) full[s] = cnt_q[s] == cnt_t'(MAX_OUT);
        eligible = src_ar_valid_i & ~full;
    end

    rr_arb3 u_rr (
        .req_i (eligible),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign gnt_idx = {gnt[2], gnt[1]};

    // AR issue FSM: IDLE captures the granted request, HOLD presents it until accepted.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        tag_d          = tag_q;
        addr_d         = addr_q;
        len_d          = len_q;
        id_d           = id_q;
        m_ar_valid_o   = 1'b0;
        src_ar_ready_o = 3'b000;
        ar_hs          = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (|eligible) begin
                tag_d   = gnt_idx;
                addr_d  = src_ar_addr_i[gnt_idx*ADDR_W +: ADDR_W];
                len_d   = src_ar_len_i[gnt_idx*8 +: 8];
                id_d    = src_ar_id_i[gnt_idx*ID_W +: ID_W];
                state_d = ARB_HOLD;
            end
        end else begin
            m_ar_valid_o = 1'b1;
            if (m_ar_ready_i) begin
                ar_hs          = 1'b1;
                src_ar_ready_o = 3'b001 << tag_q;
                ptr_d          = rr_next(tag_q);
                state_d        = ARB_IDLE;
            end
        end
    end

    assign m_ar_addr_o = addr_q;
    assign m_ar_len_o  = len_q;
    assign m_ar_id_o   = {tag_q, id_q};

    // R routing: the tag selects the requester; index 3 of r_ready_x makes bad-tag beats always ready.
    assign r_tag         = m_r_id_i[ID_W +: RD_TAG_W];
    assign r_ready_x     = {1'b1, src_r_ready_i};
    assign m_r_ready_o   = r_ready_x[r_tag];
    assign src_r_valid_o = (r_tag == RD_TAG_BAD) ? 3'b000 : {2'b00, m_r_valid_i} << r_tag;
    assign src_r_data_o  = m_r_data_i;
    assign src_r_id_o    = m_r_id_i[ID_W-1:0];
    assign src_r_resp_o  = m_r_resp_i;
    assign src_r_last_o  = m_r_last_i;
    assign r_last_hs     = m_r_valid_i & m_r_ready_o & m_r_last_i & (r_tag != RD_TAG_BAD);
    assign bad_tag_d     = bad_tag_q | (m_r_valid_i & (r_tag == RD_TAG_BAD));
    assign bad_tag_o     = bad_tag_q;

    // Outstanding counters: a grant and a final beat on the same source cancel out.
    always_comb begin
        for (int s = 0; s < 3; s++) begin
            inc[s]   = ar_hs & (tag_q == 2'(s));
            dec[s]   = r_last_hs & (r_tag == 2'(s));
            cnt_d[s] = cnt_q[s] + cnt_t'(inc[s]) - cnt_t'(dec[s]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            ptr_q     <= 2'd0;
            tag_q     <= 2'd0;
            addr_q    <= '0;
            len_q     <= '0;
            id_q      <= '0;
            cnt_q     <= '0;
            bad_tag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tag_q     <= tag_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            id_q      <= id_d;
            cnt_q     <= cnt_d;
            bad_tag_q <= bad_tag_d;
        end
    end

    for (genvar s = 0; s < 3; s++) begin : g_uflow
        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            !(dec[s] && !inc[s] && cnt_q[s] == '0));
    end

`ifdef AXI_RD_ARB_PERF_EN
    logic [2:0][31:0] perf_grant_q, perf_grant_d;
    logic [31:0]      perf_stall_q, perf_stall_d;

    always_comb begin
        for (int s = 0; s < 3; s++) perf_grant_d[s] = perf_grant_q[s] + 32'(inc[s]);
        perf_stall_d = perf_stall_q + 32'(m_ar_valid_o & ~m_ar_ready_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_grant_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_grant_q <= perf_grant_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_grant_cnt_o = perf_grant_q;
    assign perf_stall_cnt_o = perf_stall_q;
`endif
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: scoreboard bench with a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;
    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 128;
    localparam int ID_W    = 4;
    localparam int MAX_OUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]          src_ar_valid_i = '0;
    logic [2:0]          src_ar_ready_o;
    logic [3*ADDR_W-1:0] src_ar_addr_i = '0;
    logic [3*8-1:0]      src_ar_len_i = '0;
    logic [3*ID_W-1:0]   src_ar_id_i = '0;
    logic [2:0]          src_r_valid_o;
    logic [2:0]          src_r_ready_i = '0;
    logic [DATA_W-1:0]   src_r_data_o;
    logic [ID_W-1:0]     src_r_id_o;
    logic [1:0]          src_r_resp_o;
    logic                src_r_last_o;
    logic                m_ar_valid_o;
    logic                m_ar_ready_i = 1'b0;
    logic [ADDR_W-1:0]   m_ar_addr_o;
    logic [7:0]          m_ar_len_o;
    logic [ID_W+1:0]     m_ar_id_o;
    logic                m_r_valid_i = 1'b0;
    logic                m_r_ready_o;
    logic [DATA_W-1:0]   m_r_data_i = '0;
    logic [ID_W+1:0]     m_r_id_i = '0;
    logic [1:0]          m_r_resp_i = '0;
    logic                m_r_last_i = 1'b0;
    logic                bad_tag_o;
`ifdef AXI_RD_ARB_PERF_EN
    logic [3*32-1:0]     perf_grant_cnt_o;
    logic [31:0]         perf_stall_cnt_o;
`endif

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .src_ar_valid_i(src_ar_valid_i), .src_ar_ready_o(src_ar_ready_o),
        .src_ar_addr_i(src_ar_addr_i), .src_ar_len_i(src_ar_len_i), .src_ar_id_i(src_ar_id_i),
        .src_r_valid_o(src_r_valid_o), .src_r_ready_i(src_r_ready_i),
        .src_r_data_o(src_r_data_o), .src_r_id_o(src_r_id_o),
        .src_r_resp_o(src_r_resp_o), .src_r_last_o(src_r_last_o),
        .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i),
        .m_ar_addr_o(m_ar_addr_o), .m_ar_len_o(m_ar_len_o), .m_ar_id_o(m_ar_id_o),
        .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o),
        .m_r_data_i(m_r_data_i), .m_r_id_i(m_r_id_i),
        .m_r_resp_i(m_r_resp_i), .m_r_last_i(m_r_last_i),
        .bad_tag_o(bad_tag_o)
`ifdef AXI_RD_ARB_PERF_EN
        , .perf_grant_cnt_o(perf_grant_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o)
`endif
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [ID_W+1:0]   id;
    } ar_t;
    typedef struct {
        logic [2:0]        vld;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic              mrdy;
    } r_t;
    typedef struct {
        logic [ID_W-1:0] id;
        int              len;
    } ob_t;

    ar_t ar_q[$];
    r_t  r_q[$];
    ob_t ob[3][$];

    int n_vec = 0;
    int n_err = 0;

    // reference model: outstanding reads per source, next source to favour, pending grant
    int   cnt[3];
    int   ptr;
    bit   busy;
    int   gsrc;
    ob_t  gob;
    bit   exp_bad;
    bit   pend[3];
    bit   r_act;
    int   r_src;
    int   r_left;
    logic [ID_W-1:0] r_id;

    logic [2:0] mask = '0;
    int  p_req = 0, p_rdy = 0, p_rval = 0;
    bit  r_en = 0, inj_bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            cnt[s]  = 0;
            pend[s] = 0;
            ob[s].delete();
        end
        ptr = 0; busy = 0; gsrc = 0; exp_bad = 0; r_act = 0; r_left = 0;
        ar_q.delete();
        r_q.delete();
        src_ar_valid_i = '0; m_ar_ready_i = 0; m_r_valid_i = 0; m_r_last_i = 0; src_r_ready_i = '0;
    endtask

    // Apply what the clock edge just taken did, using the inputs still on the pins.
    task automatic step();
        int t;
        if (busy) begin
            if (m_ar_ready_i) begin
                cnt[gsrc]++;
                ptr = (gsrc + 1) % 3;
                busy = 0;
                pend[gsrc] = 0;
                ob[gsrc].push_back(gob);
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (ptr + k) % 3;
                if (!busy && src_ar_valid_i[s] && cnt[s] < MAX_OUT) begin
                    busy = 1;
                    gsrc = s;
                    gob.id  = src_ar_id_i[s*ID_W +: ID_W];
                    gob.len = int'(src_ar_len_i[s*8 +: 8]);
                    ar_q.push_back('{addr: src_ar_addr_i[s*ADDR_W +: ADDR_W],
                                     len: src_ar_len_i[s*8 +: 8], id: {2'(s), gob.id}});
                end
            end
        end
        if (m_r_valid_i) begin
            t = int'(m_r_id_i[ID_W+1:ID_W]);
            if (t == 3) exp_bad = 1;
            else if (src_r_ready_i[t]) begin
                r_left--;
                if (m_r_last_i) begin
                    cnt[t]--;
                    r_act = 0;
                end
            end
        end
    endtask

    task automatic drive();
        int t;
        for (int s = 0; s < 3; s++) begin
            if (pend[s] && !(busy && gsrc == s) && (!mask[s] || $urandom_range(99) < 3)) pend[s] = 0;
            else if (!pend[s] && mask[s] && $urandom_range(99) < p_req) begin
                pend[s] = 1;
                src_ar_addr_i[s*ADDR_W +: ADDR_W] = {$urandom, $urandom};
                src_ar_len_i[s*8 +: 8] = 8'($urandom_range(3));
                src_ar_id_i[s*ID_W +: ID_W] = ID_W'($urandom);
            end
            src_ar_valid_i[s] = pend[s];
        end
        m_ar_ready_i = $urandom_range(99) < p_rdy;
        if (!r_act && r_en) begin
            int st;
            st = $urandom_range(2);
            for (int k = 0; k < 3; k++) begin
                int s;
                s = (st + k) % 3;
                if (!r_act && ob[s].size() != 0) begin
                    ob_t e;
                    e = ob[s].pop_front();
                    r_act = 1; r_src = s; r_left = e.len + 1; r_id = e.id;
                end
            end
        end
        m_r_valid_i   = 0;
        m_r_last_i    = 0;
        src_r_ready_i = 3'($urandom);
        m_r_id_i      = (ID_W+2)'($urandom);
        m_r_data_i    = {$urandom, $urandom, $urandom, $urandom};
        m_r_resp_i    = 2'($urandom);
        if (inj_bad && !r_act) begin
            m_r_valid_i   = 1;
            m_r_id_i      = {2'b11, ID_W'($urandom)};
            m_r_last_i    = 1'($urandom);
            src_r_ready_i = 3'b000;
            inj_bad       = 0;
        end else if (r_act && $urandom_range(99) < p_rval) begin
            m_r_valid_i = 1;
            m_r_id_i    = {2'(r_src), r_id};
            m_r_last_i  = r_left == 1;
        end
        if (m_r_valid_i) begin
            t = int'(m_r_id_i[ID_W+1:ID_W]);
            r_q.push_back('{vld: (t == 3) ? 3'b000 : 3'b001 << t, id: m_r_id_i[ID_W-1:0],
                            data: m_r_data_i, resp: m_r_resp_i, last: m_r_last_i,
                            mrdy: (t == 3) ? 1'b1 : src_r_ready_i[t]});
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            step();
            drive();
        end
    endtask

    always @(negedge clk) begin : mon
        ar_t a;
        r_t  r;
        if (!rst) begin
            chk("ar_valid", m_ar_valid_o, ar_q.size() != 0);
            if (m_ar_valid_o && ar_q.size() != 0) begin
                a = ar_q[0];
                chk("ar_addr", m_ar_addr_o, a.addr);
                chk("ar_len", m_ar_len_o, a.len);
                chk("ar_id", m_ar_id_o, a.id);
                chk("src_ar_ready", src_ar_ready_o, m_ar_ready_i ? 3'b001 << a.id[ID_W+1:ID_W] : 3'b000);
                if (m_ar_ready_i) void'(ar_q.pop_front());
            end else chk("src_ar_ready_idle", src_ar_ready_o, 0);
            if (m_r_valid_i) begin
                if (r_q.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    r = r_q.pop_front();
                    chk("r_valid", src_r_valid_o, r.vld);
                    chk("r_id", src_r_id_o, r.id);
                    chk("r_data", src_r_data_o, r.data);
                    chk("r_resp", src_r_resp_o, r.resp);
                    chk("r_last", src_r_last_o, r.last);
                    chk("m_r_ready", m_r_ready_o, r.mrdy);
                end
            end else chk("r_valid_idle", src_r_valid_o, 0);
            chk("bad_tag", bad_tag_o, exp_bad);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ar_valid", m_ar_valid_o, 0);
        chk("rst_src_ar_ready", src_ar_ready_o, 0);
        chk("rst_src_r_valid", src_r_valid_o, 0);
        chk("rst_bad_tag", bad_tag_o, 0);
        @(posedge clk);
        #1 rst = 0;
        // all three requesting with ready tied high: order 0,1,2,0
        mask = 3'b111; p_req = 100; p_rdy = 100; r_en = 0; p_rval = 100;
        run(8);
        mask = 3'b000; r_en = 1;
        run(150);
        // src1 alone fills to MAX_OUT, then src0 still gets through, then R frees src1
        mask = 3'b010; r_en = 0;
        run(14);
        mask = 3'b011;
        run(8);
        r_en = 1;
        run(30);
        // random traffic with AR back-pressure and R stalls
        mask = 3'b111; p_req = 40; p_rdy = 20; p_rval = 60;
        run(2000);
        mask = 3'b000; p_rdy = 100; p_rval = 100;
        run(200);
        // bad tag beat with no source ready
        inj_bad = 1;
        run(4);
        chk("bad_tag_sticky", bad_tag_o, 1);
        // asynchronous reset while reads are outstanding and a request is held
        mask = 3'b111; p_req = 100; p_rdy = 30; r_en = 0;
        run(8);
        for (int i = 0; i < 20 && !m_ar_valid_o; i++) run(1);
        chk("pre_rst_hold", m_ar_valid_o, 1);
        #2 rst = 1;
        #1;
        chk("async_rst_ar_valid", m_ar_valid_o, 0);
        chk("async_rst_bad_tag", bad_tag_o, 0);
        chk("async_rst_src_ar_ready", src_ar_ready_o, 0);
        model_reset();
        mask = 3'b000;
        @(posedge clk);
        #1 rst = 0;
        // counters cleared: src1 may issue MAX_OUT new reads
        mask = 3'b010; p_req = 100; p_rdy = 100;
        run(14);
        mask = 3'b000; r_en = 1;
        run(60);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
